// File: rtl/phase_timer_if.sv
// phase_timer_if: game-control handshake to the phase sequencer and its HUD/phase outputs
interface phase_timer_if #(parameter int CNT_W = 16) ();
  logic             i_start;
  logic             i_pause;
  logic             i_skip;
  logic [1:0]       o_state_game;
  logic             o_phase_change;
  logic [CNT_W-1:0] o_ticks_left;
  logic             o_running;
  modport master (output i_start, i_pause, i_skip,
                  input  o_state_game, o_phase_change, o_ticks_left, o_running);
  modport slave  (input  i_start, i_pause, i_skip,
                  output o_state_game, o_phase_change, o_ticks_left, o_running);
endinterface

// File: rtl/phase_timer.sv
// phase_timer: cycles the game through timed phases with start, pause, skip and a HUD countdown
module phase_timer #(
  parameter int TICK_DIV   = 1_000_000,
  parameter int NUM_PHASES = 2,
  parameter int DUR0       = 125,
  parameter int DUR1       = 125,
  parameter int DUR2       = 125,
  parameter int DUR3       = 125,
  parameter int CNT_W      = 16
) (
  input logic         i_clk,
  input logic         i_rst,
  phase_timer_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t           st;
  logic [PW-1:0]    presc;
  logic [1:0]       game;
  logic [CNT_W-1:0] ticks;
  logic             pc;
  logic             running;
  logic             tick;
  logic             cnt_en;
  logic             adv;
  logic [1:0]       nxt;
  function automatic logic [CNT_W-1:0] dur(input logic [1:0] p);
    return p == 2'd0 ? CNT_W'(DUR0) :
           p == 2'd1 ? CNT_W'(DUR1) :
           p == 2'd2 ? CNT_W'(DUR2) : CNT_W'(DUR3);
  endfunction
  // Leaving PAUSED counts on the same edge, so a k-cycle pause costs exactly k cycles
  always_comb begin
    tick   = presc == PW'(TICK_DIV - 1);
    cnt_en = !bus.i_start && !bus.i_pause && st != IDLE;
    adv    = cnt_en && ((st == RUN && bus.i_skip) || (tick && ticks == CNT_W'(1)));
    nxt    = game == 2'(NUM_PHASES - 1) ? 2'd0 : game + 2'd1;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st      <= IDLE;
      presc   <= '0;
      game    <= '0;
      ticks   <= CNT_W'(DUR0);
      pc      <= 1'b0;
      running <= 1'b0;
    end else begin
      pc <= 1'b0;
      if (bus.i_start) begin
        st      <= RUN;
        presc   <= '0;
        game    <= '0;
        ticks   <= CNT_W'(DUR0);
        pc      <= 1'b1;
        running <= 1'b1;
      end else if (st != IDLE) begin
        st      <= bus.i_pause ? PAUSED : RUN;
        running <= !bus.i_pause;
        if (adv) begin
          game  <= nxt;
          ticks <= dur(nxt);
          presc <= '0;
          pc    <= 1'b1;
        end else if (cnt_en) begin
          presc <= tick ? '0 : presc + 1'b1;
          if (tick) ticks <= ticks - 1'b1;
        end
      end
    end
  end
  assign bus.o_state_game   = game;
  assign bus.o_ticks_left   = ticks;
  assign bus.o_phase_change = pc;
  assign bus.o_running      = running;
endmodule
